// File: rtl/spw_pkg.sv
// Shared definitions for the SpaceWire link-control FSM: state codes,
// default timer constants and the per-state transmitter control decode.
package spw_pkg;

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } link_state_t;

  localparam int T6U4_DEFAULT  = 640;
  localparam int T12U8_DEFAULT = 1280;
  localparam int TMR_W_DEFAULT = 12;

  typedef struct packed {
    logic rx_resetn;
    logic enable_tx;
    logic send_null_tx;
    logic send_fct_tx;
    logic send_data_tx;
  } link_ctrl_t;

  // Illegal codes decode to the ERROR_RESET controls (receiver held in reset).
  function automatic link_ctrl_t ctrl_for(input link_state_t s);
    link_ctrl_t c;
    c = '0;
    case (s)
      ST_ERROR_WAIT, ST_READY: c.rx_resetn = 1'b1;
      ST_STARTED:    c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ST_CONNECTING: c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ST_RUN:        c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      default:       c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spw_link_timer.sv
// State-dwell timer: cleared on state entry, counts every cycle, flags
// when the count reaches the selected terminal value.
module spw_link_timer #(
  parameter int TMR_W = 12
) (
  input  logic             pclk,
  input  logic             resetn,
  input  logic             clear,
  input  logic [TMR_W-1:0] terminal,
  output logic             expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (count == terminal);

endmodule

// File: rtl/spw_link_fsm.sv
// SpaceWire link-initialisation state machine. Outputs are registered from
// the next state so they switch together with fsm_state.
module spw_link_fsm
  import spw_pkg::*;
#(
  parameter int T6U4_CYCLES  = T6U4_DEFAULT,
  parameter int T12U8_CYCLES = T12U8_DEFAULT,
  parameter int TMR_W        = TMR_W_DEFAULT
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       link_start,
  input  logic       link_disable,
  input  logic       auto_start,
  input  logic       rx_got_null,
  input  logic       rx_got_fct,
  input  logic       rx_got_nchar,
  input  logic       rx_got_time_code,
  input  logic       rx_error,
  input  logic       rx_disconnect,
  input  logic       credit_error,
  output logic       rx_resetn,
  output logic       enable_tx,
  output logic       send_null_tx,
  output logic       send_fct_tx,
  output logic       send_data_tx,
  output logic [2:0] fsm_state,
  output logic       link_error
);

  localparam logic [TMR_W-1:0] TERM_SHORT = TMR_W'(T6U4_CYCLES - 1);
  localparam logic [TMR_W-1:0] TERM_LONG  = TMR_W'(T12U8_CYCLES - 1);

  link_state_t      state;
  link_state_t      next_state;
  logic             err_exit;
  logic             timeout;
  logic             timer_clear;
  logic [TMR_W-1:0] timer_term;
  link_ctrl_t       ctrl_next;
  link_ctrl_t       ctrl;
  logic             rx_fault;
  logic             rx_unexpected;

  assign rx_fault      = rx_error | rx_disconnect;
  assign rx_unexpected = rx_got_fct | rx_got_nchar | rx_got_time_code;

  assign timer_term  = (state == ST_ERROR_RESET) ? TERM_SHORT : TERM_LONG;
  assign timer_clear = (next_state != state);

  spw_link_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .pclk     (pclk),
    .resetn   (resetn),
    .clear    (timer_clear),
    .terminal (timer_term),
    .expired  (timeout)
  );

  // State and output registers
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_ERROR_RESET;
      ctrl       <= '0;
      link_error <= 1'b0;
    end else begin
      state      <= next_state;
      ctrl       <= ctrl_next;
      link_error <= err_exit;
    end
  end

  // Next state; each branch order encodes errors > disable > timeout > advance
  always_comb begin
    next_state = state;
    err_exit   = 1'b0;
    case (state)
      ST_ERROR_RESET: begin
        if (timeout) next_state = ST_ERROR_WAIT;
      end
      ST_ERROR_WAIT: begin
        if (rx_fault || rx_unexpected) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if (timeout) begin
          next_state = ST_READY;
        end
      end
      ST_READY: begin
        if (rx_fault || rx_unexpected) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if ((link_start || (auto_start && rx_got_null)) && !link_disable) begin
          next_state = ST_STARTED;
        end
      end
      ST_STARTED: begin
        if (rx_fault || rx_unexpected) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if (link_disable) begin
          next_state = ST_ERROR_RESET;
        end else if (timeout) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if (rx_got_null) begin
          next_state = ST_CONNECTING;
        end
      end
      ST_CONNECTING: begin
        if (rx_fault || rx_got_nchar || rx_got_time_code) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if (link_disable) begin
          next_state = ST_ERROR_RESET;
        end else if (timeout) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if (rx_got_fct) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rx_fault || credit_error) begin
          next_state = ST_ERROR_RESET;
          err_exit   = 1'b1;
        end else if (link_disable) begin
          next_state = ST_ERROR_RESET;
        end
      end
      default: next_state = ST_ERROR_RESET;
    endcase
  end

  // Output decode from the next state
  always_comb begin
    ctrl_next = ctrl_for(next_state);
  end

  assign fsm_state    = state;
  assign rx_resetn    = ctrl.rx_resetn;
  assign enable_tx    = ctrl.enable_tx;
  assign send_null_tx = ctrl.send_null_tx;
  assign send_fct_tx  = ctrl.send_fct_tx;
  assign send_data_tx = ctrl.send_data_tx;

endmodule

// File: tb/tb_spw_link_fsm.sv
// Scoreboard bench for spw_link_fsm: the driver advances a behavioural link
// model each cycle and queues its prediction; the monitor checks every cycle.
module tb_spw_link_fsm;

  localparam int T_SHORT = 640;
  localparam int T_LONG  = 1280;
  localparam int S_ER = 0, S_EW = 1, S_RDY = 2, S_ST = 3, S_CN = 4, S_RUN = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic link_start = 0, link_disable = 0, auto_start = 0;
  logic rx_got_null = 0, rx_got_fct = 0, rx_got_nchar = 0, rx_got_time_code = 0;
  logic rx_error = 0, rx_disconnect = 0, credit_error = 0;
  logic rx_resetn, enable_tx, send_null_tx, send_fct_tx, send_data_tx, link_error;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  spw_link_fsm dut (
    .pclk(clk), .resetn(resetn),
    .link_start(link_start), .link_disable(link_disable), .auto_start(auto_start),
    .rx_got_null(rx_got_null), .rx_got_fct(rx_got_fct), .rx_got_nchar(rx_got_nchar),
    .rx_got_time_code(rx_got_time_code), .rx_error(rx_error),
    .rx_disconnect(rx_disconnect), .credit_error(credit_error),
    .rx_resetn(rx_resetn), .enable_tx(enable_tx), .send_null_tx(send_null_tx),
    .send_fct_tx(send_fct_tx), .send_data_tx(send_data_tx),
    .fsm_state(fsm_state), .link_error(link_error)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] ctl;   // {rx_resetn, enable_tx, send_null, send_fct, send_data}
    logic       lerr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_got;
  int total = 0;
  int bad   = 0;

  // Control outputs each state must present.
  logic [4:0] ctl_tab [6] = '{5'b00000, 5'b10000, 5'b10000, 5'b11100, 5'b11110, 5'b11111};

  int m_state;
  int m_age;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_ER;
    m_age   = 0;
  endtask

  task automatic model_step();
    int   nxt;
    int   limit;
    bit   to, lerr;
    exp_t e;
    nxt  = m_state;
    lerr = 0;
    limit = (m_state == S_ER) ? T_SHORT :
            (m_state == S_EW || m_state == S_ST || m_state == S_CN) ? T_LONG : 0;
    to = (limit > 0) && (m_age == limit - 1);
    case (m_state)
      S_ER:  if (to) nxt = S_EW;
      S_EW:  if (rx_error | rx_disconnect | rx_got_fct | rx_got_nchar | rx_got_time_code) begin
               nxt = S_ER; lerr = 1;
             end else if (to) nxt = S_RDY;
      S_RDY: if (rx_error | rx_disconnect | rx_got_fct | rx_got_nchar | rx_got_time_code) begin
               nxt = S_ER; lerr = 1;
             end else if ((link_start | (auto_start & rx_got_null)) & !link_disable) nxt = S_ST;
      S_ST:  if (rx_error | rx_disconnect | rx_got_fct | rx_got_nchar | rx_got_time_code) begin
               nxt = S_ER; lerr = 1;
             end else if (link_disable) nxt = S_ER;
             else if (to) begin nxt = S_ER; lerr = 1; end
             else if (rx_got_null) nxt = S_CN;
      S_CN:  if (rx_error | rx_disconnect | rx_got_nchar | rx_got_time_code) begin
               nxt = S_ER; lerr = 1;
             end else if (link_disable) nxt = S_ER;
             else if (to) begin nxt = S_ER; lerr = 1; end
             else if (rx_got_fct) nxt = S_RUN;
      default: if (rx_error | rx_disconnect | credit_error) begin
               nxt = S_ER; lerr = 1;
             end else if (link_disable) nxt = S_ER;
    endcase
    m_age   = (nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
    e.st   = 3'(nxt);
    e.ctl  = ctl_tab[nxt];
    e.lerr = lerr;
    sb.push_back(e);
  endtask

  // One clock: receiver flags are cleared while it is held in reset.
  task automatic tick();
    if (m_state == S_ER) begin
      rx_got_null = 0; rx_got_fct = 0; rx_got_nchar = 0; rx_got_time_code = 0;
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (m_state != s && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(fsm_state), s);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_got = {fsm_state, {rx_resetn, enable_tx, send_null_tx, send_fct_tx, send_data_tx}, link_error};
      total++;
      if (mon_got !== mon_e) begin
        bad++;
        if (bad < 40)
          $display("FAIL cycle t=%0t: got state=%0d ctl=%b lerr=%b, expected state=%0d ctl=%b lerr=%b",
                   $time, mon_got.st, mon_got.ctl, mon_got.lerr, mon_e.st, mon_e.ctl, mon_e.lerr);
      end
    end
  end

  initial begin
    bit async_done = 0;
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", int'(fsm_state), S_ER);
    chk("reset_rx_resetn", int'(rx_resetn), 0);
    chk("reset_tx_ctl", int'({enable_tx, send_null_tx, send_fct_tx, send_data_tx}), 0);
    chk("reset_link_error", int'(link_error), 0);
    resetn = 1'b1;

    // Boot sequence with no inputs
    run(T_SHORT - 1);
    chk("boot_er_last", int'(fsm_state), S_ER);
    tick();
    chk("boot_ew_entry", int'(fsm_state), S_EW);
    run(T_LONG - 1);
    chk("boot_ew_last", int'(fsm_state), S_EW);
    tick();
    chk("boot_ready", int'(fsm_state), S_RDY);
    run(20);
    chk("boot_ready_hold", int'(fsm_state), S_RDY);

    // Link start through to RUN, then error together with disable
    link_start = 1;
    run(50);
    rx_got_null = 1;
    run(50);
    rx_got_fct = 1;
    run(5);
    chk("run_state", int'(fsm_state), S_RUN);
    chk("run_send_data", int'(send_data_tx), 1);
    link_start = 0;
    rx_error = 1; link_disable = 1;
    tick();
    chk("err_dis_state", int'(fsm_state), S_ER);
    chk("err_dis_lerr", int'(link_error), 1);
    rx_error = 0; link_disable = 0;
    tick();
    chk("lerr_one_cycle", int'(link_error), 0);

    // Auto-start blocked by link_disable, then credit error in RUN
    wait_state(S_RDY, 2100, "ready_again_1");
    auto_start = 1; rx_got_null = 1; link_disable = 1;
    run(10);
    chk("disable_blocks_start", int'(fsm_state), S_RDY);
    link_disable = 0;
    tick();
    chk("auto_started", int'(fsm_state), S_ST);
    auto_start = 0;
    tick();
    chk("auto_connecting", int'(fsm_state), S_CN);
    rx_got_fct = 1;
    run(3);
    chk("auto_run", int'(fsm_state), S_RUN);
    credit_error = 1;
    tick();
    chk("credit_err_state", int'(fsm_state), S_ER);
    chk("credit_err_lerr", int'(link_error), 1);
    credit_error = 0;

    // STARTED timeout without NULLs
    wait_state(S_RDY, 2100, "ready_again_2");
    link_start = 1;
    tick();
    link_start = 0;
    run(T_LONG - 1);
    chk("started_before_to", int'(fsm_state), S_ST);
    tick();
    chk("started_to_state", int'(fsm_state), S_ER);
    chk("started_to_lerr", int'(link_error), 1);
    chk("started_to_rxrst", int'(rx_resetn), 0);
    tick();
    chk("started_to_lerr_end", int'(link_error), 0);

    // Unexpected N-Char in ERROR_WAIT restarts the full reset period
    wait_state(S_EW, 700, "ew_reached");
    run(99);
    rx_got_nchar = 1;
    tick();
    chk("nchar_ew_state", int'(fsm_state), S_ER);
    chk("nchar_ew_lerr", int'(link_error), 1);
    run(T_SHORT - 1);
    chk("nchar_er_last", int'(fsm_state), S_ER);
    tick();
    chk("nchar_er_exit", int'(fsm_state), S_EW);

    // Timeout and NULL arrival in the same cycle
    wait_state(S_RDY, 1400, "ready_again_3");
    link_start = 1;
    tick();
    link_start = 0;
    run(T_LONG - 1);
    rx_got_null = 1;
    tick();
    chk("to_beats_adv_state", int'(fsm_state), S_ER);
    chk("to_beats_adv_lerr", int'(link_error), 1);

    // Randomised traffic with one asynchronous reset in an active state
    for (int i = 0; i < 25000; i++) begin
      k = (m_state == S_EW) ? 20000 : 600;
      link_start   = ($urandom_range(0, 15) == 0);
      auto_start   = $urandom_range(0, 1);
      link_disable = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) rx_got_null = 1;
      if ($urandom_range(0, (m_state == S_CN) ? 39 : 5000) == 0) rx_got_fct = 1;
      if ($urandom_range(0, k) == 0) rx_got_nchar = 1;
      if ($urandom_range(0, k) == 0) rx_got_time_code = 1;
      rx_error      = ($urandom_range(0, k) == 0);
      rx_disconnect = ($urandom_range(0, k) == 0);
      credit_error  = ($urandom_range(0, 999) == 0);
      tick();
      if (!async_done && i > 5000 && m_state >= S_ST) begin
        async_done = 1;
        #2 resetn = 1'b0;
        #1;
        chk("async_state", int'(fsm_state), S_ER);
        chk("async_rx_resetn", int'(rx_resetn), 0);
        chk("async_tx_ctl", int'({enable_tx, send_null_tx, send_fct_tx, send_data_tx}), 0);
        model_reset();
        rx_got_null = 0; rx_got_fct = 0; rx_got_nchar = 0; rx_got_time_code = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
      end
    end
    link_start = 0; link_disable = 0; rx_error = 0; rx_disconnect = 0; credit_error = 0;
    run(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
